// File: rtl/zorro3_slave_responder.sv
// zorro3_slave_responder: Zorro III target-side responder that claims cycles in the 16 MB window, runs a cs/ack handshake and terminates with DTACK_n
// Ports: bclk/IORST clock and async reset; Z_FCS_n/ADDR/READ/DS_n/DOE are the bus cycle inputs;
// mybus/cfg_base/cfg_valid gate address decode; SLAVE_n/DTACK_n/data_oe are the bus responses;
// reg_cs/reg_rw/reg_addr/reg_be/reg_ack form the local access handshake; timeout pulses on forced termination.
module zorro3_slave_responder #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int TMR_W = 7
) (
  input  logic        bclk,
  input  logic        IORST,
  input  logic        Z_FCS_n,
  input  logic [29:0] ADDR,
  input  logic        READ,
  input  logic [3:0]  DS_n,
  input  logic        DOE,
  input  logic        mybus,
  input  logic [7:0]  cfg_base,
  input  logic        cfg_valid,
  output logic        SLAVE_n,
  output logic        DTACK_n,
  output logic        data_oe,
  output logic        reg_cs,
  output logic        reg_rw,
  output logic [21:0] reg_addr,
  output logic [3:0]  reg_be,
  input  logic        reg_ack,
  output logic        timeout
);
  typedef enum logic [2:0] {IDLE, MATCH, ACCESS, ACK, RELEASE, IGNORE} state_t;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);
  state_t state_q, state_d;
  logic slave_n_q, slave_n_d, dtack_n_q, dtack_n_d, cs_q, cs_d, to_q, to_d, rw_q, rw_d;
  logic [21:0] addr_q, addr_d;
  logic [3:0] be_q, be_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic hit, abort;
  assign hit = !mybus && cfg_valid && (ADDR[29:22] == cfg_base);
  // A strobe withdrawal mid-cycle drops every bus/local output at once
  assign abort = Z_FCS_n && (state_q == MATCH || state_q == ACCESS || state_q == ACK);
  always_ff @(posedge bclk or posedge IORST) begin
    if (IORST) begin
      state_q   <= IDLE;
      slave_n_q <= 1'b1;
      dtack_n_q <= 1'b1;
      cs_q      <= 1'b0;
      to_q      <= 1'b0;
      rw_q      <= 1'b1;
      addr_q    <= '0;
      be_q      <= '0;
      tmr_q     <= '0;
    end else begin
      state_q   <= state_d;
      slave_n_q <= slave_n_d;
      dtack_n_q <= dtack_n_d;
      cs_q      <= cs_d;
      to_q      <= to_d;
      rw_q      <= rw_d;
      addr_q    <= addr_d;
      be_q      <= be_d;
      tmr_q     <= tmr_d;
    end
  end
  always_comb begin
    state_d   = state_q;
    slave_n_d = slave_n_q;
    dtack_n_d = dtack_n_q;
    cs_d      = cs_q;
    to_d      = 1'b0;
    rw_d      = rw_q;
    addr_d    = addr_q;
    be_d      = be_q;
    tmr_d     = tmr_q;
    if (abort) begin
      state_d   = IDLE;
      slave_n_d = 1'b1;
      dtack_n_d = 1'b1;
      cs_d      = 1'b0;
    end else begin
      case (state_q)
        IDLE: if (!Z_FCS_n) begin
          state_d = hit ? MATCH : IGNORE;
          slave_n_d = !hit;
          addr_d = hit ? ADDR[21:0] : addr_q;
          rw_d = hit ? READ : rw_q;
        end
        IGNORE: state_d = Z_FCS_n ? IDLE : IGNORE;
        MATCH: if (DS_n != 4'hF) begin
          be_d = ~DS_n;
          cs_d = 1'b1;
          tmr_d = '0;
          state_d = ACCESS;
        end
        ACCESS: begin
          tmr_d = (tmr_q == '1) ? tmr_q : tmr_q + 1'b1;
          // A same-edge ack beats expiry, so timeout only fires without ack
          if (reg_ack || tmr_q == TMR_LAST) begin
            cs_d = 1'b0;
            dtack_n_d = 1'b0;
            to_d = !reg_ack;
            state_d = ACK;
          end
        end
        ACK: if (DS_n == 4'hF) begin
          dtack_n_d = 1'b1;
          state_d = RELEASE;
        end
        RELEASE: if (Z_FCS_n) begin
          slave_n_d = 1'b1;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end
  assign data_oe  = rw_q && DOE && (state_q == ACCESS || state_q == ACK);
  assign SLAVE_n  = slave_n_q;
  assign DTACK_n  = dtack_n_q;
  assign reg_cs   = cs_q;
  assign reg_rw   = rw_q;
  assign reg_addr = addr_q;
  assign reg_be   = be_q;
  assign timeout  = to_q;
endmodule

// File: tb/tb_zorro3_slave_responder.sv
// tb_zorro3_slave_responder: directed plus randomized bus cycles checked against a transaction-level model
module tb_zorro3_slave_responder;
  localparam int TO = 64;
  logic bclk = 0, IORST = 0, Z_FCS_n = 1, READ = 0, DOE = 0, mybus = 0, cfg_valid = 0, reg_ack = 0;
  logic [29:0] ADDR = '0;
  logic [3:0] DS_n = 4'hF;
  logic [7:0] cfg_base = '0;
  logic SLAVE_n, DTACK_n, data_oe, reg_cs, reg_rw, timeout;
  logic [21:0] reg_addr;
  logic [3:0] reg_be;
  int tests = 0, fails = 0;
  zorro3_slave_responder #(.TIMEOUT_CYCLES(TO), .TMR_W(7)) dut (
    .bclk(bclk), .IORST(IORST), .Z_FCS_n(Z_FCS_n), .ADDR(ADDR), .READ(READ), .DS_n(DS_n),
    .DOE(DOE), .mybus(mybus), .cfg_base(cfg_base), .cfg_valid(cfg_valid), .SLAVE_n(SLAVE_n),
    .DTACK_n(DTACK_n), .data_oe(data_oe), .reg_cs(reg_cs), .reg_rw(reg_rw), .reg_addr(reg_addr),
    .reg_be(reg_be), .reg_ack(reg_ack), .timeout(timeout));
  always #5 bclk = ~bclk;
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic step;
    @(posedge bclk);
    #1;
  endtask
  function automatic logic hit_m(input logic [29:0] a);
    return !mybus && cfg_valid && (a[29:22] == cfg_base);
  endfunction
  task automatic fcs_start(input logic [29:0] a, input logic rd, output logic h);
    h = hit_m(a);
    ADDR = a;
    READ = rd;
    DS_n = 4'hF;
    Z_FCS_n = 0;
    step;
    chk("claim_slave", SLAVE_n, !h);
    chk("claim_dtack", DTACK_n, 1);
    chk("claim_cs", reg_cs, 0);
    if (h) begin
      chk("claim_addr", reg_addr, a[21:0]);
      chk("claim_rw", reg_rw, rd);
    end
  endtask
  task automatic ds_phase(input logic [3:0] ds, input logic d, input logic rd);
    logic [3:0] be;
    be = ~ds;
    DS_n = ds;
    DOE = d;
    step;
    chk("cs_rise", reg_cs, 1);
    chk("be", reg_be, be);
    chk("oe_access", data_oe, rd & d);
    chk("slave_hold", SLAVE_n, 0);
  endtask
  task automatic access_phase(input int ack_at, input logic rd, input logic d);
    int n;
    logic to;
    to = !(ack_at >= 1 && ack_at <= TO);
    n = to ? TO : ack_at;
    for (int k = 1; k <= n; k++) begin
      reg_ack = (ack_at != 0 && k >= ack_at);
      step;
      if (k < n) chk("dtack_wait", DTACK_n, 1);
    end
    chk("ack_dtack", DTACK_n, 0);
    chk("ack_cs", reg_cs, 0);
    chk("ack_timeout", timeout, to);
    chk("oe_ack", data_oe, rd & d);
    step;
    chk("timeout_pulse", timeout, 0);
    chk("dtack_hold", DTACK_n, 0);
    DS_n = 4'hF;
    step;
    chk("dtack_release", DTACK_n, 1);
    chk("slave_release", SLAVE_n, 0);
    chk("oe_release", data_oe, 0);
    reg_ack = 0;
    Z_FCS_n = 1;
    step;
    chk("slave_end", SLAVE_n, 1);
  endtask
  task automatic miss_tail;
    DS_n = 4'h0;
    for (int k = 0; k < 3; k++) begin
      step;
      chk("miss_slave", SLAVE_n, 1);
      chk("miss_dtack", DTACK_n, 1);
      chk("miss_cs", reg_cs, 0);
    end
    DS_n = 4'hF;
    Z_FCS_n = 1;
    step;
    chk("miss_end", SLAVE_n, 1);
  endtask
  task automatic full_cycle(input logic [29:0] a, input logic rd, input logic [3:0] ds, input logic d, input int ack_at);
    logic h;
    fcs_start(a, rd, h);
    if (h) begin
      ds_phase(ds, d, rd);
      access_phase(ack_at, rd, d);
    end else miss_tail;
  endtask
  initial begin
    logic h;
    logic [29:0] a;
    #1 IORST = 1;
    #2;
    chk("rst_slave", SLAVE_n, 1);
    chk("rst_dtack", DTACK_n, 1);
    chk("rst_cs", reg_cs, 0);
    chk("rst_timeout", timeout, 0);
    chk("rst_oe", data_oe, 0);
    chk("rst_rw", reg_rw, 1);
    chk("rst_addr", reg_addr, 0);
    chk("rst_be", reg_be, 0);
    @(negedge bclk);
    IORST = 0;
    step;
    cfg_base = 8'h40;
    cfg_valid = 1;
    full_cycle(30'h1000_0123, 0, 4'b0000, 0, 3);
    chk("lw_be", reg_be, 4'b1111);
    full_cycle(30'h1000_0456, 1, 4'b1110, 1, 2);
    chk("byte_be", reg_be, 4'b0001);
    full_cycle(30'h1012_3458, 0, 4'b0011, 0, 0);
    full_cycle(30'h103F_FFFF, 1, 4'b1100, 1, TO);
    full_cycle(30'h1040_0000, 1, 4'b0000, 1, 1);
    mybus = 1;
    full_cycle(30'h1000_0010, 1, 4'b0000, 1, 1);
    mybus = 0;
    cfg_valid = 0;
    full_cycle(30'h1000_0020, 0, 4'b0000, 0, 1);
    cfg_valid = 1;
    fcs_start(30'h1000_0aaa, 1, h);
    ds_phase(4'b0000, 1, 1);
    step;
    chk("abort_pre_cs", reg_cs, 1);
    Z_FCS_n = 1;
    DS_n = 4'hF;
    step;
    chk("abort_slave", SLAVE_n, 1);
    chk("abort_dtack", DTACK_n, 1);
    chk("abort_cs", reg_cs, 0);
    chk("abort_oe", data_oe, 0);
    chk("abort_addr", reg_addr, 22'h000aaa);
    chk("abort_be", reg_be, 4'hF);
    chk("abort_rw", reg_rw, 1);
    fcs_start(30'h1000_0bbb, 0, h);
    ds_phase(4'b0111, 0, 0);
    access_phase(1, 0, 0);
    fcs_start(30'h1000_0ccc, 0, h);
    Z_FCS_n = 1;
    step;
    chk("abort_match_slave", SLAVE_n, 1);
    chk("abort_match_cs", reg_cs, 0);
    fcs_start(30'h1000_0ddd, 1, h);
    ds_phase(4'b0000, 0, 1);
    step;
    #2 IORST = 1;
    #1;
    chk("arst_slave", SLAVE_n, 1);
    chk("arst_dtack", DTACK_n, 1);
    chk("arst_cs", reg_cs, 0);
    chk("arst_addr", reg_addr, 0);
    chk("arst_rw", reg_rw, 1);
    @(negedge bclk);
    IORST = 0;
    Z_FCS_n = 1;
    DS_n = 4'hF;
    step;
    full_cycle(30'h1000_0eee, 0, 4'b1010, 0, 2);
    repeat (16) begin
      mybus = ($urandom_range(0, 4) == 0);
      cfg_valid = ($urandom_range(0, 5) != 0);
      cfg_base = 8'($urandom_range(0, 255));
      a = 30'($urandom);
      if ($urandom_range(0, 3) != 0) a[29:22] = cfg_base;
      full_cycle(a, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 14)), 1'($urandom_range(0, 1)),
                 int'($urandom_range(1, 6)));
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/zorro3_slave_responder.md
# zorro3_slave_responder

Zorro III target-side cycle responder for the SCSI controller board. It decodes bus-master cycles addressed to the board's autoconfigured 16 MB window and claims them with SLAVE_n. It hands the access to the local register/SCSI port as a chip-select/ack handshake, and terminates the bus cycle with DTACK_n. It complements the board's DMA bus-master logic and stays silent whenever this board owns the bus (mybus).

## Interface
Parameters:
- TIMEOUT_CYCLES, 64: bclk cycles in ACCESS without reg_ack before a forced termination.
- TMR_W, 7: width of the timeout counter; must hold TIMEOUT_CYCLES.

Ports:
- bclk  in  1  bus clock; all state is sampled on posedge.
- IORST  in  1  asynchronous, active-high reset.
- Z_FCS_n  in  1  Zorro III full cycle strobe, active low.
- ADDR  in  30  bus address A[31:2], valid while Z_FCS_n is falling.
- READ  in  1  bus direction; 1 = read.
- DS_n  in  4  bus data strobes, active low; DS_n[3] = D31..24.
- DOE  in  1  bus data output enable.
- mybus  in  1  this board is the current bus master; responder disabled.
- cfg_base  in  8  autoconfigured A[31:24] base.
- cfg_valid  in  1  board has been configured.
- SLAVE_n  out  1  board claims the cycle, active low.
- DTACK_n  out  1  cycle termination, active low.
- data_oe  out  1  drive local read data onto the bus.
- reg_cs  out  1  local access request.
- reg_rw  out  1  latched READ.
- reg_addr  out  22  latched A[23:2].
- reg_be  out  4  latched byte enables (~DS_n).
- reg_ack  in  1  local access complete.
- timeout  out  1  one-cycle pulse on forced termination.

## Operation
- The states are IDLE, MATCH, ACCESS, ACK, RELEASE, and IGNORE.
- **IDLE.** On a posedge with Z_FCS_n=0:
  - A hit is mybus=0, cfg_valid=1 and ADDR[31:24]==cfg_base.
  - On a hit: latch reg_addr and reg_rw, drive SLAVE_n=0, go to MATCH.
  - On any other case: go to IGNORE.
- **IGNORE.** Hold all outputs inactive. Return to IDLE on Z_FCS_n=1.
- **MATCH.** On the first posedge with any DS_n bit low:
  - latch reg_be=~DS_n;
  - set reg_cs=1;
  - clear the timer;
  - go to ACCESS.
- **ACCESS.**
  - reg_cs stays 1 and the timer increments each cycle.
  - reg_ack=1 sampled: reg_cs=0, DTACK_n=0, go to ACK.
  - Timer reaches TIMEOUT_CYCLES-1 without reg_ack: same transition, plus timeout=1 for one cycle.
- **ACK.** Hold DTACK_n=0 until DS_n==4'b1111 is sampled. Then DTACK_n=1 and go to RELEASE.
- **RELEASE.** Hold SLAVE_n=0 until Z_FCS_n=1 is sampled. Then SLAVE_n=1 and go to IDLE.
- **data_oe** = reg_rw & DOE & (state is ACCESS or ACK). This is the only combinational output; all other outputs are registered.
- **reg_be** is ignored by the local side on reads; full long-word data is driven on reads.

## Timing
- **Reset values.** IORST=1 forces the following immediately, independent of bclk:
  - state IDLE;
  - SLAVE_n=1, DTACK_n=1;
  - reg_cs=0, timeout=0, data_oe=0;
  - reg_rw=1, reg_addr=0, reg_be=0, timer=0.
- **Latency.**
  - SLAVE_n goes low 1 bclk after the first posedge that samples Z_FCS_n=0.
  - reg_cs goes high 1 bclk after the first DS_n-low sample.
  - DTACK_n goes low 1 bclk after reg_ack is sampled.
  - Minimum cycle with an immediate reg_ack: FCS sample → SLAVE_n (T+1) → reg_cs (T+2 at the earliest) → DTACK_n (T+3).
- **reg_ack handshake.**
  - reg_ack is sampled only in ACCESS; a reg_ack held high outside ACCESS is ignored.
  - reg_ack and timer expiry on the same edge is treated as a normal ack; timeout stays 0.
- **Abort.**
  - Z_FCS_n=1 sampled in MATCH, ACCESS or ACK forces IDLE on that edge.
  - On that edge all outputs go inactive together: SLAVE_n=1, DTACK_n=1, reg_cs=0.
  - The latched reg_addr, reg_rw and reg_be are retained.
- **mybus.** mybus rising mid-cycle has no effect on a cycle already claimed; it is checked only in IDLE.
- **Back-to-back cycles.** A new Z_FCS_n fall is recognised on the posedge after the IDLE entry, so there is no dead cycle.
- **Timer.** The timer saturates; it never wraps within one access.

## Test plan
- **Reset.**
  - Stimulus: assert IORST mid-ACCESS (reg_cs=1).
  - Required: SLAVE_n=1, DTACK_n=1, reg_cs=0 asynchronously; state IDLE after release.
- **Longword write hit.**
  - Stimulus: cfg_base=8'h40, cfg_valid=1, ADDR=30'h1000_0123 (A[31:24]=0x40), READ=0, DS_n=0000, reg_ack after 3 cycles.
  - Required: reg_addr=22'h000123, reg_be=1111, reg_rw=0, DTACK_n low 1 cycle after reg_ack, released when DS_n=1111.
- **Byte read.**
  - Stimulus: READ=1, DS_n=1110, DOE=1.
  - Required: reg_be=0001, data_oe=1 only during ACCESS/ACK, data_oe=0 in RELEASE.
- **Miss and master cases.**
  - Stimulus: ADDR[31:24]=0x41, or mybus=1, or cfg_valid=0.
  - Required: SLAVE_n, DTACK_n and reg_cs never asserted; IDLE again after Z_FCS_n=1.
- **Timeout.**
  - Stimulus: reg_ack held 0 with TIMEOUT_CYCLES=64.
  - Required: DTACK_n=0 and a one-cycle timeout pulse 64 cycles after reg_cs rises.
- **Abort and back-to-back.**
  - Stimulus: Z_FCS_n=1 during ACCESS, then Z_FCS_n=0 on the next cycle.
  - Required: all outputs inactive on the abort edge; the second cycle is claimed with SLAVE_n low 1 bclk after the FCS sample.
